kim_mips_control_pipe: RTL and testbench



---
 rtl/kim_mips_control_pipe_if.sv | 31 +++
 rtl/kim_mips_control_pipe.sv | 144 ++++++++++++++
 tb/tb_kim_mips_control_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/kim_mips_control_pipe_if.sv
// rtl/kim_mips_control_pipe_if.sv - ID-stage inputs and pipelined control outputs of the main-control unit
interface kim_mips_control_pipe_if #(
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [OP_W-1:0]   id_op_code;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              hold;
    logic              flush;
    logic              stall;
    logic [10:0]       ex_ctrl;
    logic [10:0]       mem_ctrl;
    logic [10:0]       wb_ctrl;
    logic [REG_AW-1:0] ex_dst;
    logic [REG_AW-1:0] mem_dst;
    logic [REG_AW-1:0] wb_dst;
    logic              ex_illegal;

    modport master (
        output id_valid, id_op_code, id_rs, id_rt, id_rd, hold, flush,
        input  stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst, ex_illegal
    );

    modport slave (
        input  id_valid, id_op_code, id_rs, id_rt, id_rd, hold, flush,
        output stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst, ex_illegal
    );
endinterface

// File: rtl/kim_mips_control_pipe.sv
// rtl/kim_mips_control_pipe.sv - MIPS main-control decode with ID/EX, EX/MEM, MEM/WB control pipeline
module kim_mips_control_pipe #(
    parameter int OP_W           = 6,
    parameter int REG_AW         = 5,
    parameter int ENABLE_BNE     = 1,
    parameter int ENABLE_IMM_ALU = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    kim_mips_control_pipe_if.slave bus
);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);

    // Bit order: [10] RegDst [9] Jump [8] BranchNe [7] Branch [6] MemtoReg
    //            [5:3] ALUOp [2] MemWrite [1] ALUSrc [0] RegWrite
    localparam logic [10:0] CW_RTYPE = 11'h411;
    localparam logic [10:0] CW_LW    = 11'h043;
    localparam logic [10:0] CW_SW    = 11'h006;
    localparam logic [10:0] CW_BEQ   = 11'h088;
    localparam logic [10:0] CW_BNE   = 11'h108;
    localparam logic [10:0] CW_J     = 11'h200;
    localparam logic [10:0] CW_ADDI  = 11'h003;
    localparam logic [10:0] CW_ANDI  = 11'h01B;
    localparam logic [10:0] CW_ORI   = 11'h023;
    localparam logic [10:0] CW_SLTI  = 11'h02B;

    localparam bit BNE_ON = (ENABLE_BNE != 0);
    localparam bit IMM_ON = (ENABLE_IMM_ALU != 0);

    logic [10:0]       dec_ctrl;
    logic              dec_illegal;
    logic [REG_AW-1:0] dec_dst;
    logic              hazard;

    logic [10:0]       ex_ctrl_q,  mem_ctrl_q,  wb_ctrl_q;
    logic [REG_AW-1:0] ex_dst_q,   mem_dst_q,   wb_dst_q;
    logic              ex_illegal_q;

    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        if (bus.id_valid) begin
            case (bus.id_op_code)
                OP_RTYPE: dec_ctrl = CW_RTYPE;
                OP_LW:    dec_ctrl = CW_LW;
                OP_SW:    dec_ctrl = CW_SW;
                OP_BEQ:   dec_ctrl = CW_BEQ;
                OP_J:     dec_ctrl = CW_J;
                OP_ADDI:  dec_ctrl = CW_ADDI;
                OP_BNE: begin
                    if (BNE_ON) dec_ctrl = CW_BNE;
                    else        dec_illegal = 1'b1;
                end
                OP_ANDI: begin
                    if (IMM_ON) dec_ctrl = CW_ANDI;
                    else        dec_illegal = 1'b1;
                end
                OP_ORI: begin
                    if (IMM_ON) dec_ctrl = CW_ORI;
                    else        dec_illegal = 1'b1;
                end
                OP_SLTI: begin
                    if (IMM_ON) dec_ctrl = CW_SLTI;
                    else        dec_illegal = 1'b1;
                end
                default:  dec_illegal = 1'b1;
            endcase
        end
    end

    // A non-writing instruction carries dst 0 so it can never match a hazard compare.
    always_comb begin
        dec_dst = dec_ctrl[10] ? bus.id_rd : bus.id_rt;
        if (!dec_ctrl[0]) dec_dst = '0;
    end

    always_comb begin
        hazard = bus.id_valid && ex_ctrl_q[6] && ex_ctrl_q[0] && (ex_dst_q != '0) &&
                 ((ex_dst_q == bus.id_rs) || (ex_dst_q == bus.id_rt));
    end

    assign bus.stall = hazard && !bus.flush && !bus.hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q    <= '0;
            ex_dst_q     <= '0;
            ex_illegal_q <= 1'b0;
        end else if (!bus.hold) begin
            if (bus.flush || hazard) begin
                ex_ctrl_q    <= '0;
                ex_dst_q     <= '0;
                ex_illegal_q <= 1'b0;
            end else begin
                ex_ctrl_q    <= dec_ctrl;
                ex_dst_q     <= dec_dst;
                ex_illegal_q <= dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ctrl_q <= '0;
            mem_dst_q  <= '0;
        end else if (!bus.hold) begin
            if (bus.flush) begin
                mem_ctrl_q <= '0;
                mem_dst_q  <= '0;
            end else begin
                mem_ctrl_q <= ex_ctrl_q;
                mem_dst_q  <= ex_dst_q;
            end
        end
    end

    // The branch resolves in MEM, so the instruction already in MEM is not flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctrl_q <= '0;
            wb_dst_q  <= '0;
        end else if (!bus.hold) begin
            wb_ctrl_q <= mem_ctrl_q;
            wb_dst_q  <= mem_dst_q;
        end
    end

    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.mem_ctrl   = mem_ctrl_q;
    assign bus.wb_ctrl    = wb_ctrl_q;
    assign bus.ex_dst     = ex_dst_q;
    assign bus.mem_dst    = mem_dst_q;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_kim_mips_control_pipe.sv
// tb/tb_kim_mips_control_pipe.sv - directed vector bench for kim_mips_control_pipe
module tb_kim_mips_control_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    kim_mips_control_pipe_if #(.OP_W(6), .REG_AW(5)) a ();
    kim_mips_control_pipe_if #(.OP_W(6), .REG_AW(5)) b ();

    kim_mips_control_pipe #(.OP_W(6), .REG_AW(5), .ENABLE_BNE(1), .ENABLE_IMM_ALU(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a)
    );
    kim_mips_control_pipe #(.OP_W(6), .REG_AW(5), .ENABLE_BNE(0), .ENABLE_IMM_ALU(0)) dut_b (
        .clk(clk), .reset(reset), .bus(b)
    );

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, BADOP = 6'b111111;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        hold, flush;
        logic        stall;
        logic [10:0] ex;
        logic [4:0]  exd;
        logic        ill;
        logic [10:0] mem;
        logic [10:0] wb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic h,
                                input logic f, input logic st, input logic [10:0] ex,
                                input logic [4:0] exd, input logic ill, input logic [10:0] mem,
                                input logic [10:0] wb);
        vec_t t;
        t.valid = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.hold = h; t.flush = f;
        t.stall = st; t.ex = ex; t.exd = exd; t.ill = ill; t.mem = mem; t.wb = wb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic h,
                           input logic f);
        a.id_valid = v; a.id_op_code = op; a.id_rs = rs; a.id_rt = rt; a.id_rd = rd;
        a.hold = h; a.flush = f;
    endtask

    task automatic drive_b(input logic [5:0] op, input logic [4:0] rt);
        b.id_valid = 1'b1; b.id_op_code = op; b.id_rs = 5'd0; b.id_rt = rt; b.id_rd = 5'd0;
        b.hold = 1'b0; b.flush = 1'b0;
    endtask

    initial begin
        //                v  op    rs  rt  rd  h  f  st  ex      exd ill mem     wb
        vecs.push_back(mk(1, LW,    1,  2,  0, 0, 0, 0, 11'h043,  2, 0, 11'h000, 11'h000));
        vecs.push_back(mk(1, SW,    3,  4,  0, 0, 0, 0, 11'h006,  0, 0, 11'h043, 11'h000));
        vecs.push_back(mk(1, BEQ,   1,  1,  0, 0, 0, 0, 11'h088,  0, 0, 11'h006, 11'h043));
        vecs.push_back(mk(1, BNE,   1,  1,  0, 0, 0, 0, 11'h108,  0, 0, 11'h088, 11'h006));
        vecs.push_back(mk(1, J,     0,  0,  0, 0, 0, 0, 11'h200,  0, 0, 11'h108, 11'h088));
        vecs.push_back(mk(1, ADDI,  1,  7,  0, 0, 0, 0, 11'h003,  7, 0, 11'h200, 11'h108));
        vecs.push_back(mk(1, ANDI,  1,  8,  0, 0, 0, 0, 11'h01B,  8, 0, 11'h003, 11'h200));
        vecs.push_back(mk(1, ORI,   1,  9,  0, 0, 0, 0, 11'h023,  9, 0, 11'h01B, 11'h003));
        vecs.push_back(mk(1, SLTI,  1, 10,  0, 0, 0, 0, 11'h02B, 10, 0, 11'h023, 11'h01B));
        vecs.push_back(mk(1, BADOP, 1,  2,  3, 0, 0, 0, 11'h000,  0, 1, 11'h02B, 11'h023));
        vecs.push_back(mk(0, R,     1,  2,  3, 0, 0, 0, 11'h000,  0, 0, 11'h000, 11'h02B));
        // load-use: lw $5 then add using $5 -> one stall, bubble, then the add
        vecs.push_back(mk(1, LW,    1,  5,  0, 0, 0, 0, 11'h043,  5, 0, 11'h000, 11'h000));
        vecs.push_back(mk(1, R,     5,  6, 11, 0, 0, 1, 11'h000,  0, 0, 11'h043, 11'h000));
        vecs.push_back(mk(1, R,     5,  6, 11, 0, 0, 0, 11'h411, 11, 0, 11'h000, 11'h043));
        // lw into $0 never stalls
        vecs.push_back(mk(1, LW,    1,  0,  0, 0, 0, 0, 11'h043,  0, 0, 11'h411, 11'h000));
        vecs.push_back(mk(1, R,     0,  6, 12, 0, 0, 0, 11'h411, 12, 0, 11'h043, 11'h411));
        // flush beats a live hazard; MEM/WB still advances
        vecs.push_back(mk(1, LW,    1, 13,  0, 0, 0, 0, 11'h043, 13, 0, 11'h411, 11'h043));
        vecs.push_back(mk(1, R,    13,  2, 14, 0, 1, 0, 11'h000,  0, 0, 11'h000, 11'h411));
        // hold freezes everything, including a flush presented during it
        vecs.push_back(mk(1, R,     1,  2, 15, 0, 0, 0, 11'h411, 15, 0, 11'h000, 11'h000));
        vecs.push_back(mk(1, ADDI,  1, 16,  0, 0, 0, 0, 11'h003, 16, 0, 11'h411, 11'h000));
        vecs.push_back(mk(1, LW,    1,  2,  0, 1, 1, 0, 11'h003, 16, 0, 11'h411, 11'h000));
        vecs.push_back(mk(1, SW,    1,  2,  0, 1, 0, 0, 11'h003, 16, 0, 11'h411, 11'h000));
        vecs.push_back(mk(1, J,     0,  0,  0, 1, 1, 0, 11'h003, 16, 0, 11'h411, 11'h000));
        // hazard under hold: no stall until hold drops
        vecs.push_back(mk(1, LW,    1, 17,  0, 0, 0, 0, 11'h043, 17, 0, 11'h003, 11'h411));
        vecs.push_back(mk(1, R,    17,  2, 18, 1, 0, 0, 11'h043, 17, 0, 11'h003, 11'h411));
        vecs.push_back(mk(1, R,    17,  2, 18, 0, 0, 1, 11'h000,  0, 0, 11'h043, 11'h003));
        vecs.push_back(mk(1, R,    17,  2, 18, 0, 0, 0, 11'h411, 18, 0, 11'h000, 11'h043));

        drive_a(0, R, 0, 0, 0, 0, 0);
        b.id_valid = 1'b0; b.id_op_code = R; b.id_rs = '0; b.id_rt = '0; b.id_rd = '0;
        b.hold = 1'b0; b.flush = 1'b0;

        #1;
        check("reset ex_ctrl", a.ex_ctrl, 0);
        check("reset mem_ctrl", a.mem_ctrl, 0);
        check("reset wb_ctrl", a.wb_ctrl, 0);
        check("reset ex_illegal", a.ex_illegal, 0);
        check("reset stall", a.stall, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                    vecs[i].hold, vecs[i].flush);
            #3;
            check($sformatf("v%0d stall", i), a.stall, vecs[i].stall);
            @(posedge clk); #1;
            check($sformatf("v%0d ex_ctrl", i), a.ex_ctrl, vecs[i].ex);
            check($sformatf("v%0d ex_dst", i), a.ex_dst, vecs[i].exd);
            check($sformatf("v%0d ex_illegal", i), a.ex_illegal, vecs[i].ill);
            check($sformatf("v%0d mem_ctrl", i), a.mem_ctrl, vecs[i].mem);
            check($sformatf("v%0d wb_ctrl", i), a.wb_ctrl, vecs[i].wb);
        end

        // asynchronous reset mid-stream
        drive_a(1, R, 1, 2, 3, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst ex_ctrl", a.ex_ctrl, 0);
        check("midrst ex_dst", a.ex_dst, 0);
        check("midrst mem_ctrl", a.mem_ctrl, 0);
        check("midrst wb_ctrl", a.wb_ctrl, 0);
        check("midrst stall", a.stall, 0);
        @(posedge clk); #1;
        check("midrst held ex_ctrl", a.ex_ctrl, 0);
        check("midrst held wb_dst", a.wb_dst, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post rst ex_ctrl", a.ex_ctrl, 11'h411);
        check("post rst ex_dst", a.ex_dst, 3);
        drive_a(0, R, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("post rst mem_ctrl", a.mem_ctrl, 11'h411);
        check("post rst mem_dst", a.mem_dst, 3);
        @(posedge clk); #1;
        check("post rst wb_ctrl", a.wb_ctrl, 11'h411);
        check("post rst wb_dst", a.wb_dst, 3);

        // reduced build: bne and immediate ALU ops illegal, addi kept
        drive_b(BNE, 5'd4);
        @(posedge clk); #1;
        check("nobne ex_ctrl", b.ex_ctrl, 0);
        check("nobne ex_illegal", b.ex_illegal, 1);
        drive_b(ORI, 5'd4);
        @(posedge clk); #1;
        check("noimm ori ex_ctrl", b.ex_ctrl, 0);
        check("noimm ori ex_illegal", b.ex_illegal, 1);
        drive_b(ADDI, 5'd4);
        @(posedge clk); #1;
        check("noimm addi ex_ctrl", b.ex_ctrl, 11'h003);
        check("noimm addi ex_dst", b.ex_dst, 4);
        check("noimm addi ex_illegal", b.ex_illegal, 0);
        drive_b(SLTI, 5'd4);
        @(posedge clk); #1;
        check("noimm slti ex_illegal", b.ex_illegal, 1);
        drive_b(ANDI, 5'd4);
        @(posedge clk); #1;
        check("noimm andi ex_illegal", b.ex_illegal, 1);
        drive_b(LW, 5'd6);
        @(posedge clk); #1;
        check("reduced lw ex_ctrl", b.ex_ctrl, 11'h043);
        check("reduced lw ex_illegal", b.ex_illegal, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
